// File: rtl/uncached_dbus_responder.sv
// Uncached CPU data-bus responder.
// CPU requests are queued in a small FIFO and replayed one at a time to the
// downstream memory port. Each request gets exactly one data_ok pulse, and
// these pulses come back in the order the requests were accepted.
//
// Handshake rules:
//   - CPU side: a request transfers on a cycle where req && addr_ok are both 1.
//     addr_ok depends only on FIFO occupancy, never on req.
//   - Memory side: a request transfers on a cycle where mem_req && mem_addr_ok
//     are both 1. mem_* fields hold steady while mem_req=1 waits for mem_addr_ok.
//     A completion is the single cycle where mem_data_ok=1 while a request is
//     outstanding. At most one memory request is outstanding at a time.
module uncached_dbus_responder #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [19:0] tag,
  input  logic [7:0]  index,
  input  logic [3:0]  offset,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state, state_next;
  req_t          fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          fifo_empty;
  logic          push, pop;
  req_t          push_entry;
  req_t          head;

  // FIFO status and the CPU-side handshake; no bypass, so a full FIFO
  // refuses even in the cycle its head is being popped.
  assign fifo_empty = (count == '0);
  assign addr_ok    = (count != DEPTH_C);
  assign push       = req && addr_ok;
  assign pop        = (state == RESP);

  // Reads never carry byte enables into the queue.
  always_comb begin
    push_entry       = '0;
    push_entry.wr    = wr;
    push_entry.size  = size;
    push_entry.addr  = {tag, index, offset};
    push_entry.wstrb = wr ? wstrb : 4'b0000;
    push_entry.wdata = wdata;
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_entry;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^PW.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The head entry drives the memory request fields continuously; it only
  // changes on a pop, which cannot happen while ISSUE is presenting it.
  assign head      = fifo_mem[rd_ptr];
  assign mem_wr    = head.wr;
  assign mem_size  = head.size;
  assign mem_addr  = head.addr;
  assign mem_wstrb = head.wstrb;
  assign mem_wdata = head.wdata;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ISSUE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    data_ok    = 1'b0;
    case (state)
      ISSUE: begin
        mem_req = !fifo_empty;
        if (!fifo_empty && mem_addr_ok) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_data_ok) begin
          state_next = RESP;
        end
      end
      RESP: begin
        data_ok    = 1'b1;
        state_next = ISSUE;
      end
      default: begin
        state_next = ISSUE;
      end
    endcase
  end

  // Read data register: loaded on every completion, writes included.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if ((state == WAIT) && mem_data_ok) begin
      rdata <= mem_rdata;
    end
  end

  assign dbg_state = state;

endmodule
